// File: rtl/qrs_candidate_detect.sv
// Adaptive-threshold QRS candidate finder on the Hilbert envelope stream.
// Emits the sample index of each accepted candidate's envelope maximum.
module qrs_candidate_detect #(
   parameter int unsigned LEARN_LEN   = 720,
   parameter int unsigned REFRACT_LEN = 72,
   parameter int unsigned MIN_WIDTH   = 4,
   parameter int unsigned MAX_WIDTH   = 54,
   parameter int unsigned NOISE_WIN   = 360
) (
   input  logic        clock_IHT,
   input  logic        reset,
   input  logic [15:0] env_in,
   input  logic        env_valid,
   output logic [31:0] addr_out,
   output logic        addr_valid,
   output logic [15:0] threshold,
   output logic        learning
);

   localparam int LW = $clog2(LEARN_LEN + 1);
   localparam int RW = $clog2(MAX_WIDTH + 1);
   localparam int FW = $clog2(REFRACT_LEN + 1);
   localparam int QW = $clog2(NOISE_WIN + 1);

   localparam logic [LW-1:0] LEARN_LAST = LW'(LEARN_LEN - 1);
   localparam logic [RW-1:0] RUN_FORCE  = RW'(MAX_WIDTH - 1);
   localparam logic [RW-1:0] RUN_MIN    = RW'(MIN_WIDTH);
   localparam logic [FW-1:0] RCNT_INIT  = FW'(REFRACT_LEN);
   localparam logic [QW-1:0] QUIET_LAST = QW'(NOISE_WIN - 1);

   typedef enum logic [1:0] {LEARN, SEARCH, RISE, REFRACT} state_t;

   state_t        state;
   logic [31:0]   idx;
   logic [15:0]   spk, npk, mmax, nmax, pk_val;
   logic [31:0]   pk_idx;
   logic [LW-1:0] lcnt;
   logic [RW-1:0] run;
   logic [FW-1:0] rcnt;
   logic [QW-1:0] qcnt;

   logic [15:0] thr, diff, mmax_c, nmax_c, pkv_c;
   logic [31:0] pki_c;
   logic        above, pk_new;

   function automatic logic [15:0] lvl(input logic [15:0] l, input logic [15:0] v);
      return l - (l >> 3) + (v >> 3);
   endfunction

   always_comb begin
      diff   = spk - npk;
      thr    = (spk > npk) ? npk + (diff >> 2) : npk;
      above  = env_in > thr;
      mmax_c = (env_in > mmax) ? env_in : mmax;
      nmax_c = (env_in > nmax) ? env_in : nmax;
      pk_new = env_in > pk_val;
      pkv_c  = pk_new ? env_in : pk_val;
      pki_c  = pk_new ? idx : pk_idx;
   end

   always_ff @(posedge clock_IHT or posedge reset) begin
      if (reset) begin
         state      <= LEARN;
         idx        <= '0;
         spk        <= '0;
         npk        <= '0;
         mmax       <= '0;
         nmax       <= '0;
         pk_val     <= '0;
         pk_idx     <= '0;
         lcnt       <= '0;
         run        <= '0;
         rcnt       <= '0;
         qcnt       <= '0;
         addr_out   <= '0;
         addr_valid <= 1'b0;
         threshold  <= '0;
         learning   <= 1'b1;
      end else begin
         addr_valid <= 1'b0;
         threshold  <= thr;
         if (env_valid) begin
            idx <= idx + 32'd1;
            unique case (state)
               LEARN: begin
                  if (lcnt == LEARN_LAST) begin
                     spk      <= mmax_c;
                     npk      <= mmax_c >> 3;
                     learning <= 1'b0;
                     lcnt     <= '0;
                     mmax     <= '0;
                     state    <= SEARCH;
                  end else begin
                     lcnt <= lcnt + 1'b1;
                     mmax <= mmax_c;
                  end
               end
               SEARCH: begin
                  if (above) begin
                     pk_val <= env_in;
                     pk_idx <= idx;
                     run    <= RW'(1);
                     state  <= RISE;
                  end else if (qcnt == QUIET_LAST) begin
                     npk  <= lvl(npk, nmax_c);
                     nmax <= '0;
                     qcnt <= '0;
                  end else begin
                     nmax <= nmax_c;
                     qcnt <= qcnt + 1'b1;
                  end
               end
               RISE: begin
                  if (above) begin
                     run    <= run + 1'b1;
                     pk_val <= pkv_c;
                     pk_idx <= pki_c;
                     // too wide to wait for the falling edge: force out now
                     if (run == RUN_FORCE) begin
                        addr_out   <= pki_c;
                        addr_valid <= 1'b1;
                        spk        <= lvl(spk, pkv_c);
                        rcnt       <= RCNT_INIT;
                        state      <= REFRACT;
                     end
                  end else if (run >= RUN_MIN) begin
                     addr_out   <= pk_idx;
                     addr_valid <= 1'b1;
                     spk        <= lvl(spk, pk_val);
                     rcnt       <= RCNT_INIT;
                     state      <= REFRACT;
                  end else begin
                     npk   <= lvl(npk, pk_val);
                     state <= SEARCH;
                  end
               end
               REFRACT: begin
                  rcnt <= rcnt - 1'b1;
                  if (rcnt == FW'(1)) begin
                     nmax  <= '0;
                     qcnt  <= '0;
                     state <= SEARCH;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qrs_candidate_detect.sv
// Directed bench for qrs_candidate_detect with small window parameters;
// emitted indices are checked against a queue of expected addresses.
module tb_qrs_candidate_detect;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] env_in = '0;
   logic        env_valid = 1'b0;
   logic [31:0] addr_out;
   logic        addr_valid;
   logic [15:0] threshold;
   logic        learning;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] sb[$];

   qrs_candidate_detect #(
      .LEARN_LEN(8),
      .REFRACT_LEN(4),
      .MIN_WIDTH(2),
      .MAX_WIDTH(6),
      .NOISE_WIN(8)
   ) dut (
      .clock_IHT(clk),
      .reset(rst),
      .env_in(env_in),
      .env_valid(env_valid),
      .addr_out(addr_out),
      .addr_valid(addr_valid),
      .threshold(threshold),
      .learning(learning)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic s(input logic [15:0] v);
      @(negedge clk);
      env_in = v;
      env_valid = 1'b1;
   endtask

   task automatic se(input logic [15:0] v, input logic [31:0] a);
      @(negedge clk);
      env_in = v;
      env_valid = 1'b1;
      sb.push_back(a);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         env_in = 16'hBEEF;
         env_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      env_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Pulse check one edge after each deciding sample; also flags spurious pulses.
   always @(posedge clk) begin
      logic        exp_v;
      logic [31:0] e;
      #1;
      exp_v = (sb.size() > 0);
      if (exp_v || addr_valid !== 1'b0) begin
         n_vec++;
         assert (addr_valid === exp_v) else begin
            n_err++;
            $error("FAIL addr_valid: got %b want %b", addr_valid, exp_v);
         end
         if (exp_v) begin
            e = sb.pop_front();
            n_vec++;
            assert (addr_out === e) else begin
               n_err++;
               $error("FAIL addr_out: got %0d want %0d", addr_out, e);
            end
         end
      end
   end

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_addr", addr_out, 0);
      chk("rst_valid", {31'd0, addr_valid}, 0);
      chk("rst_thr", {16'd0, threshold}, 0);
      chk("rst_learn", {31'd0, learning}, 1);
      rst = 1'b0;

      // warm-up: one emission, then reset in the middle of a pulse
      repeat (7) s(0);
      s(400);
      gap(2);
      chk("warm_thr", {16'd0, threshold}, 137);
      s(500);
      s(600);
      se(0, 9);
      s(0); s(0); s(0); s(0);
      s(500);
      s(600);
      @(negedge clk);
      rst = 1'b1;
      env_valid = 1'b0;
      @(negedge clk);
      chk("abort_addr", addr_out, 0);
      chk("abort_valid", {31'd0, addr_valid}, 0);
      chk("abort_learn", {31'd0, learning}, 1);
      chk("abort_thr", {16'd0, threshold}, 0);
      rst = 1'b0;

      // learning window
      s(0); s(100); s(800); s(50); s(0); s(0); s(0);
      gap(1);
      chk("learn_mid", {31'd0, learning}, 1);
      s(0);
      gap(2);
      chk("learn_done", {31'd0, learning}, 0);
      chk("learn_thr", {16'd0, threshold}, 275);

      // first detected QRS: peak 900 at idx 11
      s(0); s(300); s(500); s(900); s(400);
      se(100, 11);
      gap(2);
      chk("qrs_thr", {16'd0, threshold}, 278);

      // refractory: large pulse ignored
      s(2000); s(2000); s(2000); s(0);
      gap(2);
      chk("refr_thr", {16'd0, threshold}, 278);

      // too-narrow pulse feeds the noise level
      s(600);
      s(0);
      gap(2);
      chk("narrow_thr", {16'd0, threshold}, 325);

      // forced emission at max width, first maximum kept
      s(1000); s(1000); s(1000); s(1000); s(1000);
      se(1000, 20);
      s(1000); s(1000); s(1000); s(1000);
      gap(2);
      chk("force_thr", {16'd0, threshold}, 331);

      // quiet window updates the noise level
      s(200);
      repeat (7) s(0);
      gap(2);
      chk("noise_thr", {16'd0, threshold}, 335);

      // same QRS with env_valid gaps
      do_reset();
      chk("gap_rst_thr", {16'd0, threshold}, 0);
      s(0); s(100); s(800); s(50); s(0); s(0); s(0); s(0);
      gap(2);
      chk("gap_learn_thr", {16'd0, threshold}, 275);
      s(0); gap(1);
      s(300); gap(1);
      s(500); gap(1);
      s(900); gap(1);
      s(400); gap(1);
      se(100, 11);
      gap(3);
      chk("gap_thr", {16'd0, threshold}, 278);
      chk("gap_learn", {31'd0, learning}, 0);

      // all-zero learning: threshold 0, any nonzero sample crosses
      do_reset();
      repeat (8) s(0);
      gap(2);
      chk("zero_thr", {16'd0, threshold}, 0);
      s(1);
      s(1);
      se(0, 8);
      gap(3);

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
